trap_monitor: RTL and testbench

//  Parametrised exception/trap supervisor between the execute stage and the PC register.

---
 rtl/trap_mon_pkg.sv | 22 ++
 rtl/trap_monitor_exc_prio_enc.sv | 22 ++
 rtl/trap_monitor.sv | 134 +++++++++++++
 tb/tb_trap_monitor.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/trap_mon_pkg.sv
// Shared types and default constants for the trap monitor.
// The default masks decode the 8-line exception bus: fatal bits 0-2, ECALL bit 3, EBREAK bit 4.
package trap_mon_pkg;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_RUN   = 3'd1,
    ST_TRAP  = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam int NEXC_DEF = 8;
  localparam int CAUSE_W  = $clog2(NEXC_DEF);
  localparam int CNT_W_DEF = 16;

  localparam logic [7:0]  FATAL_MASK_DEF = 8'b0000_0111;
  localparam logic [7:0]  TRAP_MASK_DEF  = 8'b0000_1000;
  localparam logic [7:0]  HALT_MASK_DEF  = 8'b0001_0000;
  localparam logic [63:0] TRAP_VEC_DEF   = 64'h8000_0100;

endpackage

// File: rtl/trap_monitor_exc_prio_enc.sv
// Lowest-index priority encoder: idx is the lowest set bit of vec, any flags a non-empty vec.
module exc_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  always_comb begin
    idx = '0;
    // scan downwards so the lowest set bit is the last one written
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/trap_monitor.sv
// Exception/trap supervisor between execute and the PC register.
// Optional per-cause saturating counters are built when TRAP_MON_COUNT_EN is defined.
//
//  state | meaning
//  RST   | held in reset, PC frozen
//  RUN   | normal execution, PC advances unless an exception or redirect is pending
//  TRAP  | one cycle, redirect to the trap vector in flight
//  HALT  | stopped on EBREAK until resume
//  ERROR | fatal exception, terminal until reset
module trap_monitor
  import trap_mon_pkg::*;
#(
  parameter int               XLEN       = 64,
  parameter int               NEXC       = NEXC_DEF,
  parameter logic [NEXC-1:0]  FATAL_MASK = NEXC'(FATAL_MASK_DEF),
  parameter logic [NEXC-1:0]  TRAP_MASK  = NEXC'(TRAP_MASK_DEF),
  parameter logic [NEXC-1:0]  HALT_MASK  = NEXC'(HALT_MASK_DEF),
  parameter logic [XLEN-1:0]  TRAP_VEC   = XLEN'(TRAP_VEC_DEF),
  parameter int               CNT_W      = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NEXC-1:0]         exc_i,
  input  logic [XLEN-1:0]         pc_i,
  input  logic                    mret_i,
  input  logic                    resume_i,
  output logic                    pc_we_o,
  output logic                    redirect_valid_o,
  output logic [XLEN-1:0]         redirect_pc_o,
  output logic [2:0]              state_o,
  output logic [$clog2(NEXC)-1:0] cause_o,
  output logic [XLEN-1:0]         epc_o,
  output logic                    halted_o,
  output logic                    error_o,
  input  logic [$clog2(NEXC)-1:0] cnt_sel_i,
  output logic [CNT_W-1:0]        cnt_o
);

  localparam int CW = $clog2(NEXC);

  state_e          state_q, state_d;
  logic [NEXC-1:0] fatal_v, trap_v, halt_v;
  logic [CW-1:0]   fatal_idx, trap_idx, halt_idx, win_idx;
  logic            fatal_any, trap_any, halt_any, exc_any;
  logic            take_exc, take_mret;

  assign fatal_v = exc_i & FATAL_MASK;
  assign trap_v  = exc_i & TRAP_MASK;
  assign halt_v  = exc_i & HALT_MASK;

  exc_prio_enc #(.N(NEXC)) u_enc_fatal (.vec(fatal_v), .idx(fatal_idx), .any(fatal_any));
  exc_prio_enc #(.N(NEXC)) u_enc_trap  (.vec(trap_v),  .idx(trap_idx),  .any(trap_any));
  exc_prio_enc #(.N(NEXC)) u_enc_halt  (.vec(halt_v),  .idx(halt_idx),  .any(halt_any));

  assign exc_any = fatal_any | trap_any | halt_any;

  // class outranks index: a fatal bit wins even if a trap bit sits lower
  always_comb begin
    win_idx = halt_idx;
    if (fatal_any)     win_idx = fatal_idx;
    else if (trap_any) win_idx = trap_idx;
  end

  always_comb begin
    state_d   = state_q;
    take_exc  = 1'b0;
    take_mret = 1'b0;
    case (state_q)
      ST_RST:  state_d = ST_RUN;
      ST_RUN: begin
        if (exc_any) begin
          take_exc = 1'b1;
          if (fatal_any)     state_d = ST_ERROR;
          else if (trap_any) state_d = ST_TRAP;
          else               state_d = ST_HALT;
        end else if (mret_i) begin
          take_mret = 1'b1;
        end
      end
      ST_TRAP:  state_d = ST_RUN;
      ST_HALT:  if (resume_i) state_d = ST_RUN;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= ST_RST;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      cause_o          <= '0;
      epc_o            <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_o <= 1'b0;
      if (take_exc) begin
        cause_o <= win_idx;
        if (state_d == ST_TRAP) begin
          epc_o            <= pc_i;
          redirect_valid_o <= 1'b1;
          redirect_pc_o    <= TRAP_VEC;
        end
      end else if (take_mret) begin
        redirect_valid_o <= 1'b1;
        redirect_pc_o    <= epc_o + XLEN'(4);
      end
    end
  end

  assign pc_we_o  = (state_q == ST_RUN) & ~exc_any & ~redirect_valid_o;
  assign state_o  = state_q;
  assign halted_o = (state_q == ST_HALT);
  assign error_o  = (state_q == ST_ERROR);

`ifdef TRAP_MON_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NEXC];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NEXC; i++) cnt_q[i] <= '0;
    end else if (take_exc && (cnt_q[win_idx] != {CNT_W{1'b1}})) begin
      cnt_q[win_idx] <= cnt_q[win_idx] + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q[cnt_sel_i];
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel_i;
  assign cnt_o          = '0;
`endif

endmodule

// File: tb/tb_trap_monitor.sv
// Directed table-driven bench for trap_monitor plus counter sequences (TRAP_MON_COUNT_EN aware).
module tb_trap_monitor;

  localparam logic [63:0] TV  = 64'h8000_0100;
  localparam logic [63:0] PCD = 64'h8000_000C;

  logic        clk = 1'b1;
  logic        rst;
  logic [7:0]  exc_i;
  logic [63:0] pc_i;
  logic        mret_i, resume_i;
  logic        pc_we_o, redirect_valid_o, halted_o, error_o;
  logic [63:0] redirect_pc_o, epc_o;
  logic [2:0]  state_o, cause_o, cnt_sel_i;
  logic [1:0]  cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trap_monitor #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .exc_i(exc_i), .pc_i(pc_i), .mret_i(mret_i),
    .resume_i(resume_i), .pc_we_o(pc_we_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .state_o(state_o), .cause_o(cause_o),
    .epc_o(epc_o), .halted_o(halted_o), .error_o(error_o),
    .cnt_sel_i(cnt_sel_i), .cnt_o(cnt_o)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  exc;
    logic [63:0] pc;
    logic        mret;
    logic        resume;
    logic        chk_we;
    logic        we;
    logic [2:0]  st;
    logic        rv;
    logic [63:0] rpc;
    logic [2:0]  cause;
    logic [63:0] epc;
    logic        halt;
    logic        err;
  } vec_t;

  vec_t v[34];

  function automatic vec_t mk(logic r, logic [7:0] e, logic [63:0] p, logic m, logic rs,
                              logic cw, logic w, logic [2:0] s, logic rv, logic [63:0] rpc,
                              logic [2:0] c, logic [63:0] epc, logic h, logic er);
    vec_t t;
    t.rst = r; t.exc = e; t.pc = p; t.mret = m; t.resume = rs;
    t.chk_we = cw; t.we = w; t.st = s; t.rv = rv; t.rpc = rpc;
    t.cause = c; t.epc = epc; t.halt = h; t.err = er;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic trap_once(input logic [63:0] p);
    exc_i = 8'h08; pc_i = p;
    @(posedge clk); #1;
    exc_i = 8'h00;
    @(posedge clk); #1;
  endtask

  initial begin
    //            rst exc    pc                      mr rs cw we st rv rpc    cause epc                    h  e
    v[0]  = mk(0, 8'h00, PCD,                    0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0,                 0, 0);
    v[1]  = mk(0, 8'h00, PCD,                    0, 0, 1, 0, 0, 0, 64'h0, 0, 64'h0,                 0, 0);
    v[2]  = mk(0, 8'h00, PCD,                    0, 0, 1, 0, 0, 0, 64'h0, 0, 64'h0,                 0, 0);
    v[3]  = mk(1, 8'h00, PCD,                    0, 0, 1, 0, 1, 0, 64'h0, 0, 64'h0,                 0, 0);
    v[4]  = mk(1, 8'h00, PCD,                    0, 0, 1, 1, 1, 0, 64'h0, 0, 64'h0,                 0, 0);
    v[5]  = mk(1, 8'h08, 64'h8000_0010,          0, 0, 1, 0, 2, 1, TV,    3, 64'h8000_0010,         0, 0);
    v[6]  = mk(1, 8'h00, PCD,                    1, 0, 1, 0, 1, 0, TV,    3, 64'h8000_0010,         0, 0);
    v[7]  = mk(1, 8'h00, PCD,                    1, 0, 1, 1, 1, 1, 64'h8000_0014, 3, 64'h8000_0010, 0, 0);
    v[8]  = mk(1, 8'h00, PCD,                    0, 0, 1, 0, 1, 0, 64'h8000_0014, 3, 64'h8000_0010, 0, 0);
    v[9]  = mk(1, 8'h00, PCD,                    0, 0, 1, 1, 1, 0, 64'h8000_0014, 3, 64'h8000_0010, 0, 0);
    v[10] = mk(1, 8'h10, 64'h8000_0020,          0, 0, 1, 0, 3, 0, 64'h8000_0014, 4, 64'h8000_0010, 1, 0);
    v[11] = mk(1, 8'h08, 64'h8000_0020,          0, 0, 1, 0, 3, 0, 64'h8000_0014, 4, 64'h8000_0010, 1, 0);
    v[12] = mk(1, 8'h00, 64'h8000_0020,          0, 1, 1, 0, 1, 0, 64'h8000_0014, 4, 64'h8000_0010, 0, 0);
    v[13] = mk(1, 8'h00, 64'h8000_0020,          0, 0, 1, 1, 1, 0, 64'h8000_0014, 4, 64'h8000_0010, 0, 0);
    v[14] = mk(1, 8'h08, 64'h8000_0030,          1, 0, 1, 0, 2, 1, TV,    3, 64'h8000_0030,         0, 0);
    v[15] = mk(1, 8'h00, PCD,                    0, 0, 1, 0, 1, 0, TV,    3, 64'h8000_0030,         0, 0);
    v[16] = mk(1, 8'h80, PCD,                    0, 0, 1, 1, 1, 0, TV,    3, 64'h8000_0030,         0, 0);
    v[17] = mk(1, 8'h80, PCD,                    1, 0, 1, 1, 1, 1, 64'h8000_0034, 3, 64'h8000_0030, 0, 0);
    v[18] = mk(1, 8'h08, 64'h8000_0040,          0, 0, 1, 0, 2, 1, TV,    3, 64'h8000_0040,         0, 0);
    v[19] = mk(0, 8'h00, PCD,                    0, 0, 1, 0, 0, 0, 64'h0, 0, 64'h0,                 0, 0);
    v[20] = mk(1, 8'h00, PCD,                    0, 0, 1, 0, 1, 0, 64'h0, 0, 64'h0,                 0, 0);
    v[21] = mk(1, 8'h00, PCD,                    0, 0, 1, 1, 1, 0, 64'h0, 0, 64'h0,                 0, 0);
    v[22] = mk(1, 8'h1C, PCD,                    0, 0, 1, 0, 4, 0, 64'h0, 2, 64'h0,                 0, 1);
    v[23] = mk(1, 8'h08, PCD,                    0, 1, 1, 0, 4, 0, 64'h0, 2, 64'h0,                 0, 1);
    v[24] = mk(1, 8'h10, PCD,                    0, 0, 1, 0, 4, 0, 64'h0, 2, 64'h0,                 0, 1);
    v[25] = mk(1, 8'h00, PCD,                    1, 1, 1, 0, 4, 0, 64'h0, 2, 64'h0,                 0, 1);
    v[26] = mk(0, 8'h00, PCD,                    0, 0, 1, 0, 0, 0, 64'h0, 0, 64'h0,                 0, 0);
    v[27] = mk(1, 8'h00, PCD,                    0, 0, 1, 0, 1, 0, 64'h0, 0, 64'h0,                 0, 0);
    v[28] = mk(1, 8'h18, 64'h8000_0050,          0, 0, 1, 0, 2, 1, TV,    3, 64'h8000_0050,         0, 0);
    v[29] = mk(1, 8'h00, PCD,                    0, 0, 1, 0, 1, 0, TV,    3, 64'h8000_0050,         0, 0);
    v[30] = mk(1, 8'h08, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 0, 2, 1, TV,   3, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    v[31] = mk(1, 8'h00, PCD,                    0, 0, 1, 0, 1, 0, TV,    3, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    v[32] = mk(1, 8'h00, PCD,                    1, 0, 1, 1, 1, 1, 64'h2, 3, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    v[33] = mk(1, 8'h00, PCD,                    0, 0, 1, 0, 1, 0, 64'h2, 3, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);

    cnt_sel_i = 3'd3;
    for (int i = 0; i < 34; i++) begin
      rst = v[i].rst; exc_i = v[i].exc; pc_i = v[i].pc;
      mret_i = v[i].mret; resume_i = v[i].resume;
      @(negedge clk);
      if (v[i].chk_we) chk("pc_we", i, 64'(pc_we_o), 64'(v[i].we));
      @(posedge clk); #1;
      chk("state",    i, 64'(state_o),          64'(v[i].st));
      chk("redir_v",  i, 64'(redirect_valid_o), 64'(v[i].rv));
      chk("redir_pc", i, redirect_pc_o,         v[i].rpc);
      chk("cause",    i, 64'(cause_o),          64'(v[i].cause));
      chk("epc",      i, epc_o,                 v[i].epc);
      chk("halted",   i, 64'(halted_o),         64'(v[i].halt));
      chk("error",    i, 64'(error_o),          64'(v[i].err));
    end

    // two ECALLs accepted since the last reset (vectors 28 and 30)
    mret_i = 1'b0; resume_i = 1'b0;
`ifdef TRAP_MON_COUNT_EN
    chk("cnt3_two", 100, 64'(cnt_o), 64'd2);
`else
    chk("cnt3_two", 100, 64'(cnt_o), 64'd0);
`endif
    for (int k = 0; k < 5; k++) trap_once(64'h8000_0200 + 64'(k * 4));
`ifdef TRAP_MON_COUNT_EN
    chk("cnt3_sat", 101, 64'(cnt_o), 64'd3);
`else
    chk("cnt3_sat", 101, 64'(cnt_o), 64'd0);
`endif
    cnt_sel_i = 3'd2;
    #1 chk("cnt2_zero", 102, 64'(cnt_o), 64'd0);
    chk("state_end", 103, 64'(state_o), 64'd1);
    chk("epc_end",   104, epc_o, 64'h8000_0210);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
